// File: rtl/map_color_pkg.sv
// map_color_pkg: shared states, field offsets and constants for the colouring search
package map_color_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
    localparam int NUM_CAND = 1024;
    localparam int IDX_W = 10;
    localparam int GC_LSB = 8;
    localparam int WC_LSB = 6;
    localparam int QC_LSB = 4;
    localparam int MC_LSB = 2;
    localparam int EC_LSB = 0;
    localparam int EXPECTED_SOLUTIONS = 72;
endpackage

// File: rtl/map_color_search_checker.sv
// map_color: combinational check that no two adjacent Oz regions share a colour
module map_color (
    input  logic [1:0] gc,
    input  logic [1:0] wc,
    input  logic [1:0] qc,
    input  logic [1:0] mc,
    input  logic [1:0] ec,
    output logic       valid
);
    // Outer regions form the ring GC-WC-QC-MC-GC; EC touches all four
    assign valid = (gc != wc) && (wc != qc) && (qc != mc) && (mc != gc) &&
                   (ec != gc) && (ec != wc) && (ec != qc) && (ec != mc);
endmodule

// File: rtl/map_color_search.sv
// map_color_search: exhaustive scan of all colourings, streaming the valid ones out
module map_color_search
    import map_color_pkg::*;
#(
    parameter int CNT_W         = 8,
    parameter bit STOP_ON_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [9:0]       out_coloring,
    output logic [CNT_W-1:0] count
);
    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [9:0]       out_coloring_q, out_coloring_d;
    logic             cand_ok, slot_free, load, advance;

    map_color u_check (
        .gc    (idx_q[GC_LSB +: 2]),
        .wc    (idx_q[WC_LSB +: 2]),
        .qc    (idx_q[QC_LSB +: 2]),
        .mc    (idx_q[MC_LSB +: 2]),
        .ec    (idx_q[EC_LSB +: 2]),
        .valid (cand_ok)
    );

    always_comb begin
        slot_free      = !out_valid_q || out_ready;
        load           = (state_q == SCAN) && cand_ok && slot_free;
        advance        = (state_q == SCAN) && (!cand_ok || slot_free);
        state_d        = state_q;
        idx_d          = advance ? idx_q + 1'b1 : idx_q;
        count_d        = load ? ((count_q == '1) ? count_q : count_q + 1'b1) : count_q;
        out_coloring_d = load ? idx_q : out_coloring_q;
        out_valid_d    = load ? 1'b1 : (out_valid_q && out_ready) ? 1'b0 : out_valid_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = SCAN;
                idx_d   = '0;
                count_d = '0;
            end
            SCAN: if (advance && (idx_q == IDX_W'(NUM_CAND - 1) || (STOP_ON_FIRST && load)))
                state_d = DRAIN;
            DRAIN: if (slot_free) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            count_q        <= '0;
            out_valid_q    <= 1'b0;
            out_coloring_q <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            count_q        <= count_d;
            out_valid_q    <= out_valid_d;
            out_coloring_q <= out_coloring_d;
        end
    end

    assign busy         = (state_q == SCAN) || (state_q == DRAIN);
    assign done         = (state_q == DONE);
    assign out_valid    = out_valid_q;
    assign out_coloring = out_coloring_q;
    assign count        = count_q;
endmodule

// File: tb/tb_map_color_search.sv
// tb_map_color_search: randomized handshake scans checked against an enumerated solution list
module tb_map_color_search;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, start1 = 1'b0;
    logic       out_ready = 1'b1, out_ready1 = 1'b1;
    logic       busy, done, out_valid, busy1, done1, out_valid1;
    logic [9:0] out_coloring, out_coloring1;
    logic [7:0] count, count1;
    int         checks = 0, failures = 0;
    int         exp_q[$];
    int         got[$];

    always #5 clk = ~clk;

    map_color_search #(.CNT_W(8), .STOP_ON_FIRST(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_coloring(out_coloring), .count(count)
    );

    map_color_search #(.CNT_W(8), .STOP_ON_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_coloring(out_coloring1), .count(count1)
    );

    function automatic bit legal(int c);
        int g = (c / 256) % 4, w = (c / 64) % 4, q = (c / 16) % 4, m = (c / 4) % 4, e = c % 4;
        return g != w && w != q && q != m && m != g && e != g && e != w && e != q && e != m;
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // mode 0: ready always, 1: ready 30% random, 2: stall on first solution, 3: stray start pulses
    task automatic run_scan(input int mode, input string tag, output int done_cyc);
        int stall = 0;
        got.delete();
        done_cyc = -1;
        start = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 6000 && done_cyc < 0; k++) begin
            start = (mode == 3 && k == 100);
            if (mode == 1) out_ready = ($urandom_range(99) < 30);
            else if (mode == 2 && out_valid && got.size() == 0 && stall < 25) begin
                out_ready = 1'b0;
                check({tag, "_stall_data"}, out_coloring, exp_q[0]);
                check({tag, "_stall_cnt"}, count, 1);
                stall++;
            end else out_ready = 1'b1;
            if (out_valid && out_ready) got.push_back(out_coloring);
            if (done) begin
                done_cyc = k;
                check({tag, "_xfers_at_done"}, got.size(), exp_q.size());
                check({tag, "_count"}, count, exp_q.size());
                if (mode == 3) start = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
        check({tag, "_done_seen"}, int'(done_cyc > 0), 1);
        for (int i = 0; i < exp_q.size(); i++)
            check({tag, "_stream"}, (i < got.size()) ? got[i] : -1, exp_q[i]);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int dc, bad, xc;
        for (int c = 0; c < 1024; c++) if (legal(c)) exp_q.push_back(c);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_coloring, 0);
        check("rst_count", count, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_scan(0, "full", dc);
        check("full_done_cycle", dc, 1026);

        run_scan(2, "stall", dc);
        check("stall_done_cycle", dc, 1026 + 25);

        run_scan(1, "rand", dc);

        run_scan(3, "stray", dc);
        check("stray_done_cycle", dc, 1026);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy || done) bad++;
            @(negedge clk);
        end
        check("stray_no_restart", bad, 0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (500) @(negedge clk);
        check("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_coloring, 0);
        check("mid_rst_count", count, 0);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_idle", busy, 0);
        @(negedge clk);
        run_scan(0, "after_rst", dc);
        check("after_rst_done_cycle", dc, 1026);

        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        dc = -1;
        xc = -1;
        got.delete();
        for (int k = 1; k <= 2000 && dc < 0; k++) begin
            if (out_valid1 && out_ready1) begin
                got.push_back(out_coloring1);
                xc = k;
            end
            if (done1) dc = k;
            @(negedge clk);
        end
        check("sof_xfers", got.size(), 1);
        check("sof_data", (got.size() > 0) ? got[0] : -1, exp_q[0]);
        check("sof_count", count1, 1);
        check("sof_xfer_cycle", xc, exp_q[0] + 2);
        check("sof_done_cycle", dc, exp_q[0] + 3);
        check("sof_busy_after", busy1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
